writeback_queue: RTL and testbench

Register-file write-port sequencer for the 16-bit core. It accepts result writes from the ALU and the load unit and buffers them in a small in-order FIFO. It drains the FIFO one entry per cycle onto the register file's single write port (`reg_write` / `write_reg` / `write_data`). It also publishes a per-register pending mask, which decode uses to stall on read-after-write hazards against queued writes.

---
 rtl/writeback_queue.sv | 102 ++++++++++
 tb/tb_writeback_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Register-file write-port sequencer: merges ALU and load results into an in-order
// FIFO, drains one entry per cycle onto the write port, and publishes a pending mask.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [ADDR_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]         alu_data,
    output logic                      alu_ready,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_rd,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      ld_ready,
    input  logic                      drain_en,
    output logic                      reg_write,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic [(1<<ADDR_W)-1:0]    pending,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

    logic [ADDR_W-1:0] mem_rd   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  alu_slot;
    logic [PTR_W-1:0]  scan_idx;
    logic              ld_store;
    logic              alu_store;
    logic              pop;
    logic [CNT_W-1:0]  count_next;

    // Readiness looks only at registered occupancy; the ALU needs two free slots
    // whenever a load is competing, since the load always takes the first one.
    assign ld_ready  = (count < CNT_FULL);
    assign alu_ready = ld_valid ? (count < CNT_ALMOST) : (count < CNT_FULL);

    assign ld_store   = ld_valid & ld_ready & (ld_rd != '0);
    assign alu_store  = alu_valid & alu_ready & (alu_rd != '0);
    assign pop        = drain_en & (count != '0);
    assign alu_slot   = tail + PTR_W'(ld_store);
    assign count_next = count + CNT_W'(ld_store) + CNT_W'(alu_store) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            tail      <= tail + PTR_W'(ld_store) + PTR_W'(alu_store);
            count     <= count_next;
            reg_write <= pop;
            if (pop) begin
                head       <= head + PTR_W'(1);
                write_reg  <= mem_rd[head];
                write_data <= mem_data[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (ld_store) begin
                mem_rd[tail]   <= ld_rd;
                mem_data[tail] <= ld_data;
            end
            if (alu_store) begin
                mem_rd[alu_slot]   <= alu_rd;
                mem_data[alu_slot] <= alu_data;
            end
        end
    end

    // Hazard mask covers every live FIFO slot plus the write currently on the port.
    always_comb begin
        pending  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                pending[mem_rd[scan_idx]] = 1'b1;
            end
        end
        if (reg_write) begin
            pending[write_reg] = 1'b1;
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed, table-driven bench for writeback_queue with a few hand-written
// multi-cycle sequences for drain gaps and ordering.
module tb_writeback_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        drain_en;
    logic        reg_write;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic [15:0] pending;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    bit monitor_on = 0;
    logic [2:0] prev_count = '0;

    writeback_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .drain_en(drain_en), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .pending(pending), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] adat;
        logic        lv;
        logic [3:0]  lrd;
        logic [15:0] ldat;
        logic        dr;
        logic        e_ar;
        logic        e_lr;
        logic        e_rw;
        logic [3:0]  e_wr;
        logic [15:0] e_wd;
        logic [15:0] e_pend;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic av, input logic [3:0] ard,
                           input logic [15:0] adat, input logic lv, input logic [3:0] lrd,
                           input logic [15:0] ldat, input logic dr, input logic e_ar,
                           input logic e_lr, input logic e_rw, input logic [3:0] e_wr,
                           input logic [15:0] e_wd, input logic [15:0] e_pend,
                           input logic [2:0] e_cnt);
        vec_t v;
        v = '{r, av, ard, adat, lv, lrd, ldat, dr, e_ar, e_lr, e_rw, e_wr, e_wd, e_pend, e_cnt};
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst       = v.rst;
        alu_valid = v.av;
        alu_rd    = v.ard;
        alu_data  = v.adat;
        ld_valid  = v.lv;
        ld_rd     = v.lrd;
        ld_data   = v.ldat;
        drain_en  = v.dr;
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Occupancy must never exceed the FIFO size and a write must never follow an empty cycle.
    always @(negedge clk) begin
        if (monitor_on) begin
            if (count > 3'd4) begin
                errors++;
                $display("[TB] FAIL count_bound: got %0d, limit 4", count);
            end
            if (reg_write === 1'b1 && prev_count == 3'd0) begin
                errors++;
                $display("[TB] FAIL pop_empty: reg_write=1 after count 0");
            end
        end
        prev_count = count;
    end

    localparam logic [15:0] NA = 16'h0000;

    logic       pat_dr [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       pat_rw [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] pat_wr [7] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    logic [2:0] pat_ct [7] = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};

    initial begin
        rst = 1'b0; alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h1111;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; drain_en = 1'b1;

        //       rst av ard   adat      lv lrd   ldat      dr | ar lr rw wr     wd        pend      cnt
        // reset with input activity, then no stray write
        add_vec(0, 1, 4'd5, 16'h1111, 0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        // single ALU write
        add_vec(1, 1, 4'd5, 16'h1234, 0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0020, 3'd1);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd5, 16'h1234, 16'h0020, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd5, 16'h1234, 16'h0000, 3'd0);
        // simultaneous sources: load is older
        add_vec(1, 1, 4'd7, 16'h5555, 1, 4'd3, 16'hAAAA, 1,  1, 1, 0, 4'd5, 16'h1234, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd5, 16'h1234, 16'h0088, 3'd2);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd3, 16'hAAAA, 16'h0088, 3'd1);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd7, 16'h5555, 16'h0080, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       0,  1, 1, 0, 4'd7, 16'h5555, 16'h0000, 3'd0);
        // fill and backpressure
        add_vec(1, 1, 4'd1, 16'h0101, 0, 4'd0, NA,       0,  1, 1, 0, 4'd7, 16'h5555, 16'h0000, 3'd0);
        add_vec(1, 1, 4'd2, 16'h0202, 0, 4'd0, NA,       0,  1, 1, 0, 4'd7, 16'h5555, 16'h0002, 3'd1);
        add_vec(1, 1, 4'd4, 16'h0404, 0, 4'd0, NA,       0,  1, 1, 0, 4'd7, 16'h5555, 16'h0006, 3'd2);
        add_vec(1, 1, 4'd6, 16'h0606, 1, 4'd8, 16'h0808, 0,  0, 1, 0, 4'd7, 16'h5555, 16'h0016, 3'd3);
        add_vec(1, 1, 4'd6, 16'h0606, 0, 4'd0, NA,       0,  0, 0, 0, 4'd7, 16'h5555, 16'h0116, 3'd4);
        add_vec(1, 1, 4'd6, 16'h0606, 1, 4'd9, 16'h0909, 0,  0, 0, 0, 4'd7, 16'h5555, 16'h0116, 3'd4);
        add_vec(1, 1, 4'd6, 16'h0606, 0, 4'd0, NA,       1,  0, 0, 0, 4'd7, 16'h5555, 16'h0116, 3'd4);
        add_vec(1, 1, 4'd6, 16'h0606, 0, 4'd0, NA,       1,  1, 1, 1, 4'd1, 16'h0101, 16'h0116, 3'd3);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd2, 16'h0202, 16'h0154, 3'd3);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd4, 16'h0404, 16'h0150, 3'd2);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd8, 16'h0808, 16'h0140, 3'd1);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd6, 16'h0606, 16'h0040, 3'd0);
        // register 0 write is accepted but dropped
        add_vec(1, 1, 4'd0, 16'hFFFF, 0, 4'd0, NA,       1,  1, 1, 0, 4'd6, 16'h0606, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd6, 16'h0606, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd6, 16'h0606, 16'h0000, 3'd0);
        // reset mid-operation with 3 entries queued
        add_vec(1, 1, 4'hA, 16'h0A0A, 1, 4'hB, 16'h0B0B, 0,  1, 1, 0, 4'd6, 16'h0606, 16'h0000, 3'd0);
        add_vec(1, 1, 4'hC, 16'h0C0C, 0, 4'd0, NA,       0,  1, 1, 0, 4'd6, 16'h0606, 16'h0C00, 3'd2);
        add_vec(0, 1, 4'hD, 16'h0D0D, 0, 4'd0, NA,       1,  1, 1, 0, 4'd6, 16'h0606, 16'h1C00, 3'd3);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        // two queued writes to the same register keep pending high through both
        add_vec(1, 1, 4'd5, 16'h005B, 1, 4'd5, 16'h005A, 1,  1, 1, 0, 4'd0, 16'h0000, 16'h0000, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 0, 4'd0, 16'h0000, 16'h0020, 3'd2);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd5, 16'h005A, 16'h0020, 3'd1);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       1,  1, 1, 1, 4'd5, 16'h005B, 16'h0020, 3'd0);
        add_vec(1, 0, 4'd0, NA,       0, 4'd0, NA,       0,  1, 1, 0, 4'd5, 16'h005B, 16'h0000, 3'd0);

        tick();
        monitor_on = 1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #2;
            check_output("alu_ready",  i, 32'(alu_ready),  32'(vecs[i].e_ar));
            check_output("ld_ready",   i, 32'(ld_ready),   32'(vecs[i].e_lr));
            check_output("reg_write",  i, 32'(reg_write),  32'(vecs[i].e_rw));
            check_output("write_reg",  i, 32'(write_reg),  32'(vecs[i].e_wr));
            check_output("write_data", i, 32'(write_data), 32'(vecs[i].e_wd));
            check_output("pending",    i, 32'(pending),    32'(vecs[i].e_pend));
            check_output("count",      i, 32'(count),      32'(vecs[i].e_cnt));
            tick();
        end

        // drain_en gaps: three queued writes drained with a one-cycle hole
        alu_valid = 1'b0; ld_valid = 1'b0; drain_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            alu_valid = 1'b1;
            alu_rd    = 4'(k);
            alu_data  = 16'(k * 16'h1001);
            tick();
        end
        alu_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drain_en = pat_dr[k];
            #2;
            check_output("gap.reg_write", 100 + k, 32'(reg_write), 32'(pat_rw[k]));
            check_output("gap.count",     100 + k, 32'(count),     32'(pat_ct[k]));
            if (pat_rw[k]) begin
                check_output("gap.write_reg",  100 + k, 32'(write_reg),  32'(pat_wr[k]));
                check_output("gap.write_data", 100 + k, 32'(write_data), 32'(pat_wr[k] * 16'h1001));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
